result_packer: RTL

- Sits directly downstream of one DPE datapath in the MVM tile.
- Collects the serial OPREC-bit results from the datapath (`o_valid`/`o_result`) and packs consecutive results into DATAW-wide words.
- Buffers packed words in a small FIFO and presents them on a ready/valid interface to the MVM output / NoC injection logic.
- The datapath has no backpressure, so this block absorbs bursts and flags overflow when it cannot.

---
 rtl/result_packer.sv | 115 +++++++++++
 1 files changed

// File: rtl/result_packer.sv
`default_nettype none
// ============================================================================
// Module      : result_packer
// Description : Packs serial datapath results into wide words and buffers them
//               in a small first-word-fall-through FIFO with ready/valid output.
// Revision    : 1.0 - initial release
// ============================================================================
module result_packer #(
    parameter int OPREC      = 32,
    parameter int DATAW      = 512,
    parameter int ELEMS      = DATAW / OPREC,
    parameter int FIFO_DEPTH = 4,
    parameter int CNTW       = $clog2(ELEMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [OPREC-1:0] i_result,
    input  logic             i_flush,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [DATAW-1:0] o_data,
    output logic             o_last,
    output logic [CNTW-1:0]  o_count,
    output logic             o_overflow
);

    localparam int c_PTRW = $clog2(FIFO_DEPTH);
    localparam int c_OCCW = $clog2(FIFO_DEPTH + 1);

    logic [DATAW-1:0]      r_word;
    logic [CNTW-1:0]       r_count;
    logic [DATAW-1:0]      r_mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_mem_last;
    logic [c_PTRW-1:0]     r_wr_ptr;
    logic [c_PTRW-1:0]     r_rd_ptr;
    logic [c_OCCW-1:0]     r_occ;
    logic                  r_overflow;

    logic [DATAW-1:0]      w_word_ins;
    logic                  w_full_close;
    logic                  w_flush_close;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push_ok;
    logic                  w_drop;

    // Partial word with the incoming element dropped into slot r_count.
    for (genvar k = 0; k < ELEMS; k++) begin : g_slot
        assign w_word_ins[k*OPREC +: OPREC] =
            (i_valid && (r_count == CNTW'(k))) ? i_result : r_word[k*OPREC +: OPREC];
    end

    assign w_full_close  = i_valid && (r_count == CNTW'(ELEMS - 1));
    assign w_flush_close = i_flush && ((r_count != '0) || i_valid);
    assign w_push        = w_full_close || w_flush_close;
    assign w_pop         = o_valid && i_ready;
    assign w_full        = (r_occ == c_OCCW'(FIFO_DEPTH));
    assign w_push_ok     = w_push && (!w_full || w_pop);
    assign w_drop        = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (w_push) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_valid) begin
            r_word  <= w_word_ins;
            r_count <= r_count + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push_ok) begin
            r_mem_data[r_wr_ptr] <= w_word_ins;
            r_mem_last[r_wr_ptr] <= i_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTRW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTRW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_occ <= r_occ + c_OCCW'(1);
            end else if (!w_push_ok && w_pop) begin
                r_occ <= r_occ - c_OCCW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Outputs are forced quiet while reset is held so the head never shows stale data.
    assign o_valid    = rst && (r_occ != '0);
    assign o_data     = o_valid ? r_mem_data[r_rd_ptr] : '0;
    assign o_last     = o_valid && r_mem_last[r_rd_ptr];
    assign o_count    = rst ? r_count : '0;
    assign o_overflow = rst && r_overflow;

endmodule
`default_nettype wire
